// File: rtl/radix5_pkg.sv
// Shared definitions for the radix-5 butterfly back end.
//   DefaultW  : default bits per real/imag word
//   DefaultNp : complex words per butterfly result frame (a, b, c)
//   cplx_t    : one complex word {re, im}
//   frame_t   : one full parallel result frame
package radix5_pkg;

  localparam int unsigned DefaultW  = 32;
  localparam int unsigned DefaultNp = 3;

  typedef struct packed {
    logic [DefaultW-1:0] re;
    logic [DefaultW-1:0] im;
  } cplx_t;

  typedef cplx_t [DefaultNp-1:0] frame_t;

endpackage

// File: rtl/radix5_frame_fifo.sv
// Frame FIFO: stores whole parallel frames, one write and one pop per cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   wr_en_i       : store wr_data_i at the write pointer (caller guarantees room)
//   wr_data_i     : frame payload
//   rd_en_i       : retire the frame at the read pointer (caller guarantees non-empty)
//   rd_data_o     : frame at the read pointer
//   cnt_o         : frames held, 0..Depth
module radix5_frame_fifo #(
  parameter int unsigned Width = 192,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [Width-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [Width-1:0]           rd_data_o,
  output logic [$clog2(Depth+1)-1:0] cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Storage carries no reset; nothing reads it while the count is zero.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en_i, rd_en_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/radix5_frame_collector.sv
// Captures parallel radix-5 butterfly result frames and replays them as a serial
// complex stream with valid/ready backpressure. Issue credits bound launches to
// what the frame FIFO can hold.
//   clk, rst_n           : clock, async active-low reset
//   issue_i / credit_o   : upstream launch / launch permitted
//   in_valid, in_re/img  : parallel result frame, word k at [k*W +: W]
//   out_valid/ready      : serial handshake
//   out_re/img, out_idx  : current word and its position in the frame
//   out_last             : final word of the frame
//   ovf_err              : sticky, a frame arrived with no room and was dropped
// Build option RADIX5_COLL_LAT_CHECK_EN adds lat_err: sticky, in_valid did not
// follow a counted launch by exactly LAT cycles.
module radix5_frame_collector
  import radix5_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned NP    = DefaultNp,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LAT   = 38
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_i,
  output logic            credit_o,
  input  logic            in_valid,
  input  logic [NP*W-1:0] in_re,
  input  logic [NP*W-1:0] in_img,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_re,
  output logic [W-1:0]    out_img,
  output logic [2:0]      out_idx,
  output logic            out_last,
  output logic            ovf_err
`ifdef RADIX5_COLL_LAT_CHECK_EN
  ,
  output logic            lat_err
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [CntW-1:0]   cred_cnt_q, cred_cnt_d;
  logic [CntW-1:0]   fifo_cnt;
  logic [2:0]        idx_q;
  logic              ovf_err_q;
  logic              launch, pop_word, pop_last, wr_en;
  logic [2*NP*W-1:0] rd_data;

  assign credit_o = (cred_cnt_q < CntW'(DEPTH));
  assign launch   = issue_i && credit_o;
  assign pop_word = out_valid && out_ready;
  assign pop_last = pop_word && (idx_q == 3'(NP-1));
  // A final-word pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign wr_en    = in_valid && ((fifo_cnt < CntW'(DEPTH)) || pop_last);

  always_comb begin
    cred_cnt_d = cred_cnt_q;
    unique case ({launch, pop_last})
      2'b10:   cred_cnt_d = cred_cnt_q + 1'b1;
      2'b01:   cred_cnt_d = cred_cnt_q - 1'b1;
      default: cred_cnt_d = cred_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred_cnt_q <= '0;
      idx_q      <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      cred_cnt_q <= cred_cnt_d;
      if (pop_word) idx_q <= pop_last ? 3'd0 : idx_q + 3'd1;
      if (in_valid && !wr_en) ovf_err_q <= 1'b1;
    end
  end

  radix5_frame_fifo #(
    .Width (2*NP*W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i ({in_img, in_re}),
    .rd_en_i   (pop_last),
    .rd_data_o (rd_data),
    .cnt_o     (fifo_cnt)
  );

  // Stored layout is {img[NP], re[NP]}.
  assign out_valid = (fifo_cnt != '0);
  assign out_re    = out_valid ? rd_data[int'(idx_q)*W +: W] : '0;
  assign out_img   = out_valid ? rd_data[NP*W + int'(idx_q)*W +: W] : '0;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == 3'(NP-1));
  assign ovf_err   = ovf_err_q;

`ifdef RADIX5_COLL_LAT_CHECK_EN
  logic [LAT-1:0] launch_sr_q;
  logic           lat_err_q;

  // Bit LAT-1 holds the launch decision from exactly LAT cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch_sr_q <= '0;
      lat_err_q   <= 1'b0;
    end else begin
      launch_sr_q <= {launch_sr_q[LAT-2:0], launch};
      if (in_valid != launch_sr_q[LAT-1]) lat_err_q <= 1'b1;
    end
  end

  assign lat_err = lat_err_q;
`else
  logic unused_lat;
  assign unused_lat = (LAT != 0);
`endif

endmodule

// File: tb/tb_radix5_frame_collector.sv
// Directed bench for radix5_frame_collector with hand-computed expectations.
module tb_radix5_frame_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_i;
  logic        credit_o;
  logic        in_valid;
  logic [95:0] in_re, in_img;
  logic        out_valid, out_ready;
  logic [31:0] out_re, out_img;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        ovf_err;
`ifdef RADIX5_COLL_LAT_CHECK_EN
  logic        lat_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_bases[$];

  always #5 clk = ~clk;

  radix5_frame_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (issue_i),
    .credit_o  (credit_o),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .ovf_err   (ovf_err)
`ifdef RADIX5_COLL_LAT_CHECK_EN
    ,
    .lat_err   (lat_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns just after a rising edge, where outputs are stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of a frame: re = base+2k+1, im = base+2k+2.
  task automatic set_frame(input logic [31:0] base);
    in_re  = {base + 32'd5, base + 32'd3, base + 32'd1};
    in_img = {base + 32'd6, base + 32'd4, base + 32'd2};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; issue_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_img = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic fill8(input logic [31:0] step);
    for (int k = 0; k < 8; k++) begin
      set_frame(32'(k) * step);
      issue_i = 1'b1; in_valid = 1'b1;
      tick();
    end
    issue_i = 1'b0; in_valid = 1'b0;
  endtask

  // Pulls words for a bounded number of cycles and checks them against exp_bases.
  task automatic drain(input string tag, input int exp_words);
    int n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (n < exp_words) begin
          check_eq({tag, "_re"}, 64'(out_re), 64'(exp_bases[n/3] + 32'(2*(n%3) + 1)));
          check_eq({tag, "_idx"}, 64'(out_idx), 64'(n % 3));
        end
        n++;
      end
      tick();
    end
    out_ready = 1'b0;
    check_eq({tag, "_count"}, 64'(n), 64'(exp_words));
  endtask

  initial begin
    // 1: reset values, then one frame serialised in order.
    rst_n = 1'b0; issue_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_img = '0;
    #3;
    check_eq("rst_credit", 64'(credit_o), 64'd1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ovf", 64'(ovf_err), 64'd0);
    check_eq("rst_re", 64'(out_re), 64'd0);
    check_eq("rst_last", 64'(out_last), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    set_frame(32'd0); issue_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    issue_i = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("t1_valid", 64'(out_valid), 64'd1);
      check_eq("t1_re", 64'(out_re), 64'(2*k + 1));
      check_eq("t1_img", 64'(out_img), 64'(2*k + 2));
      check_eq("t1_idx", 64'(out_idx), 64'(k));
      check_eq("t1_last", 64'(out_last), 64'(k == 2));
      tick();
    end
    check_eq("t1_empty", 64'(out_valid), 64'd0);
    check_eq("t1_credit", 64'(credit_o), 64'd1);

    // 2: credit exhaustion and return.
    do_reset();
    issue_i = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check_eq("t2_credit7", 64'(credit_o), 64'd1);
    tick();
    check_eq("t2_credit8", 64'(credit_o), 64'd0);
    tick(); // ignored launch
    issue_i = 1'b0;
    set_frame(32'h40); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_eq("t2_last", 64'(out_last), 64'd1);
    check_eq("t2_credit_pre", 64'(credit_o), 64'd0);
    tick();
    check_eq("t2_credit_back", 64'(credit_o), 64'd1);
    out_ready = 1'b0;

    // 3: stall holds the word stable.
    do_reset();
    set_frame(32'h10); issue_i = 1'b1; in_valid = 1'b1;
    tick();
    issue_i = 1'b0; in_valid = 1'b0;
    begin
      logic [3:0] rdy_pat;
      logic [2:0] exp_idx [5];
      rdy_pat = 4'b1001; // per cycle, bit 3 first: 1,0,0,1
      exp_idx = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
      for (int c = 0; c < 5; c++) begin
        out_ready = (c < 4) ? rdy_pat[3-c] : 1'b1;
        check_eq("t3_idx", 64'(out_idx), 64'(exp_idx[c]));
        check_eq("t3_re", 64'(out_re), 64'(32'h10 + 32'(2*exp_idx[c] + 1)));
        check_eq("t3_img", 64'(out_img), 64'(32'h10 + 32'(2*exp_idx[c] + 2)));
        tick();
      end
    end
    check_eq("t3_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // 4: overflow drops the ninth frame.
    do_reset();
    fill8(32'h100);
    check_eq("t4_ovf_pre", 64'(ovf_err), 64'd0);
    set_frame(32'h900); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t4_ovf", 64'(ovf_err), 64'd1);
    exp_bases.delete();
    for (int k = 0; k < 8; k++) exp_bases.push_back(32'(k) * 32'h100);
    drain("t4", 24);
    check_eq("t4_ovf_sticky", 64'(ovf_err), 64'd1);

    // 5: full FIFO accepts a frame when the final-word pop coincides.
    do_reset();
    fill8(32'h100);
    out_ready = 1'b1;
    tick(); tick();
    check_eq("t5_idx2", 64'(out_idx), 64'd2);
    set_frame(32'h500); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("t5_ovf", 64'(ovf_err), 64'd0);
    exp_bases.delete();
    for (int k = 1; k < 8; k++) exp_bases.push_back(32'(k) * 32'h100);
    exp_bases.push_back(32'h500);
    drain("t5", 24);

    // Mid-frame reset returns outputs immediately.
    do_reset();
    set_frame(32'h20); issue_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    issue_i = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("mid_idx_pre", 64'(out_idx), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_valid", 64'(out_valid), 64'd0);
    check_eq("mid_re", 64'(out_re), 64'd0);
    check_eq("mid_idx", 64'(out_idx), 64'd0);
    check_eq("mid_credit", 64'(credit_o), 64'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;

`ifdef RADIX5_COLL_LAT_CHECK_EN
    // 6: result exactly LAT cycles after launch is clean; one cycle early is flagged.
    do_reset();
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    repeat (37) tick();
    set_frame(32'h0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t6_lat_ok", 64'(lat_err), 64'd0);
    do_reset();
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    repeat (36) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("t6_lat_early", 64'(lat_err), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
